// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state encodings shared by the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_MUL = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_OR  = 4'd4,
    OP_NOR = 4'd5,
    OP_SR  = 4'd6,
    OP_LW  = 4'd7,
    OP_SW  = 4'd8,
    OP_SLT = 4'd11,
    OP_SET = 4'd13,
    OP_SL  = 4'd14
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_OUT     = 2'd2
  } state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      OP_MUL, OP_ADD, OP_SUB, OP_OR, OP_NOR, OP_SR,
      OP_LW, OP_SW, OP_SLT, OP_SET, OP_SL: is_legal_op = 1'b1;
      default:                             is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - radix-2 shift-add multiplier, one partial product per cycle.
module alu_mul_iter #(
  parameter int D_WIDTH = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [D_WIDTH-1:0]     a,
  input  logic [D_WIDTH-1:0]     b,
  output logic                   busy,
  output logic                   done,
  output logic [2*D_WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(D_WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(D_WIDTH - 1);

  logic [2*D_WIDTH-1:0] mcand_q, mcand_d;
  logic [2*D_WIDTH-1:0] acc_q, acc_d;
  logic [D_WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (load) begin
      mcand_d  = {{D_WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  // done marks the cycle whose edge performs the final iteration
  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == LAST);
  assign product = acc_q;

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU: single-cycle ops plus iterative MUL behind start/ready/valid.
module alu_mc
  import alu_pkg::*;
#(
  parameter int D_WIDTH  = 34,
  parameter int C_WIDTH  = 4,
  parameter int SH_WIDTH = $clog2(D_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [C_WIDTH-1:0] control_i,
  input  logic [D_WIDTH-1:0] input0_i,
  input  logic [D_WIDTH-1:0] input1_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [D_WIDTH-1:0] result_o,
  output logic               zero_o,
  output logic               equal_o,
  output logic               neg_o,
  output logic               ovf_o,
  output logic               illegal_o
);

  state_e state_q, state_d;
  logic [D_WIDTH-1:0] result_q, result_d;
  logic zero_q, zero_d, eq_q, eq_d, neg_q, neg_d, ovf_q, ovf_d, ill_q, ill_d;
  logic valid_q, valid_d, mul_eq_q, mul_eq_d;

  logic                   mul_load, mul_busy, mul_done;
  logic [2*D_WIDTH-1:0]   mul_product;
  logic [D_WIDTH-1:0]     alu_res;
  logic                   alu_ovf, accept, in_out, shift_oob, sa, sb;
  logic [SH_WIDTH-1:0]    sh_amt;

  alu_mul_iter #(.D_WIDTH(D_WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .load    (mul_load),
    .a       (input0_i),
    .b       (input1_i),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  assign ready_o   = (state_q != ST_MUL_RUN);
  assign accept    = start_i & ready_o;
  assign in_out    = (state_q == ST_OUT);
  assign shift_oob = (input0_i >= D_WIDTH'(D_WIDTH));
  assign sh_amt    = input0_i[SH_WIDTH-1:0];
  assign sa        = input0_i[D_WIDTH-1];
  assign sb        = input1_i[D_WIDTH-1];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (control_i)
      OP_ADD: begin
        alu_res = input0_i + input1_i;
        alu_ovf = (sa == sb) && (alu_res[D_WIDTH-1] != sa);
      end
      OP_SUB: begin
        alu_res = input0_i - input1_i;
        alu_ovf = (sa != sb) && (alu_res[D_WIDTH-1] != sa);
      end
      OP_LW, OP_SW: alu_res = input0_i + input1_i;
      OP_OR:        alu_res = input0_i | input1_i;
      OP_NOR:       alu_res = ~(input0_i | input1_i);
      OP_SR:        alu_res = shift_oob ? '0 : (input1_i >> sh_amt);
      OP_SL:        alu_res = shift_oob ? '0 : (input1_i << sh_amt);
      OP_SET:       alu_res = input1_i;
      OP_SLT:       alu_res = {{(D_WIDTH-1){1'b0}}, ($signed(input0_i) < $signed(input1_i))};
      default:      alu_res = '0;
    endcase
  end

  // During OUT the outputs come straight from the product register; the
  // same values are copied into the holding registers as OUT ends.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    eq_d     = eq_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    mul_eq_d = mul_eq_q;
    valid_d  = 1'b0;
    mul_load = 1'b0;
    if (state_q == ST_MUL_RUN) begin
      if (mul_done || !mul_busy) state_d = ST_OUT;
    end else begin
      state_d = ST_IDLE;
      if (in_out) begin
        result_d = mul_product[D_WIDTH-1:0];
        zero_d   = (mul_product[D_WIDTH-1:0] == '0);
        neg_d    = mul_product[D_WIDTH-1];
        ovf_d    = |mul_product[2*D_WIDTH-1:D_WIDTH];
        eq_d     = mul_eq_q;
        ill_d    = 1'b0;
      end
      if (accept) begin
        if (control_i == OP_MUL) begin
          mul_load = 1'b1;
          mul_eq_d = (input0_i == input1_i);
          state_d  = ST_MUL_RUN;
        end else begin
          result_d = alu_res;
          zero_d   = (alu_res == '0);
          neg_d    = alu_res[D_WIDTH-1];
          ovf_d    = alu_ovf;
          eq_d     = (input0_i == input1_i);
          ill_d    = !is_legal_op(control_i);
          valid_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      eq_q     <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      mul_eq_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      eq_q     <= eq_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      mul_eq_q <= mul_eq_d;
      valid_q  <= valid_d;
    end
  end

  assign valid_o   = valid_q | in_out;
  assign result_o  = in_out ? mul_product[D_WIDTH-1:0] : result_q;
  assign zero_o    = in_out ? (mul_product[D_WIDTH-1:0] == '0) : zero_q;
  assign neg_o     = in_out ? mul_product[D_WIDTH-1] : neg_q;
  assign ovf_o     = in_out ? (|mul_product[2*D_WIDTH-1:D_WIDTH]) : ovf_q;
  assign equal_o   = in_out ? mul_eq_q : eq_q;
  assign illegal_o = ~in_out & ill_q;

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Single-cycle ops (add/sub/logic/shift/set/slt/address calc) produce a registered result 1 cycle after acceptance.
- MUL becomes an iterative radix-2 shift-add unit, removing the wide combinational multiplier from the critical path.
- A start/ready/valid handshake lets the control unit stall the pipeline during MUL. Registered flags (zero, equal, negative, overflow, illegal) are added.

Parameters:
- D_WIDTH, 34, data width of operands and result.
- C_WIDTH, 4, width of the opcode/control field.
- SH_WIDTH, $clog2(D_WIDTH), number of low bits of input0_i that form the shift amount.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start_i  input  1  request; accepted on a rising edge when start_i & ready_o.
- control_i  input  C_WIDTH  opcode, captured at acceptance.
- input0_i  input  D_WIDTH  operand A; also the shift amount for SR/SL.
- input1_i  input  D_WIDTH  operand B; also the shifted value and the SET source.
- ready_o  output  1  high when IDLE; low while MUL iterates.
- valid_o  output  1  single-cycle pulse; result_o and the flags are valid during it.
- result_o  output  D_WIDTH  registered result.
- zero_o  output  1  result_o == 0.
- equal_o  output  1  captured operands were equal (for BEQ/BNE).
- neg_o  output  1  result_o[D_WIDTH-1].
- ovf_o  output  1  signed overflow (ADD/SUB) or nonzero truncated high product (MUL).
- illegal_o  output  1  opcode is not in the supported set.

Behaviour:
- Opcodes: MUL=1, ADD=2, SUB=3, OR=4, NOR=5, SR=6, LW=7, SW=8, SLT=11, SET=13, SL=14.
  - LW/SW compute A+B.
  - SET returns B.
  - SR returns B>>amt (logical); SL returns B<<amt.
  - If the full input0_i >= D_WIDTH, SR and SL return 0.
  - SLT is a true signed compare: result 1 if A<B signed, else 0, including when A-B overflows.
  - All other codes (0, 9, 10, 12, 15): result 0, illegal_o=1.
- Reset: state=IDLE, ready_o=1. valid_o, result_o and all flags are 0. Any in-flight MUL is aborted with no valid_o pulse.
- FSM states IDLE, MUL_RUN, OUT.
- IDLE, accept of a non-MUL op at edge k:
  - result and flags are registered at edge k.
  - valid_o=1 during cycle k+1.
  - ready_o stays 1, giving back-to-back throughput of 1 op/cycle.
- IDLE, accept of MUL at edge k:
  - Latch A and B, clear the accumulator, counter=0, go to MUL_RUN, ready_o=0.
- MUL_RUN:
  - Each cycle: if multiplier bit0 then acc += multiplicand. Then multiplicand <<= 1, multiplier >>= 1, counter++.
  - Arithmetic is performed over 2*D_WIDTH bits.
  - After D_WIDTH iterations go to OUT.
- OUT (one cycle):
  - result_o = acc[D_WIDTH-1:0]; ovf_o = |acc[2D-1:D].
  - valid_o=1, ready_o=1 again, state returns to IDLE.
  - A start_i in this cycle is accepted.
- MUL timing: accepted at edge k, valid_o high during cycle k+D_WIDTH+1; ready_o is low during cycles k+1 .. k+D_WIDTH.
- start_i while ready_o=0 is ignored, not queued.
- Operands and control are sampled only at acceptance; later input changes do not affect the op in flight.
- Flags are computed from the final result; equal_o comes from the captured A==B. All outputs except ready_o hold their values between valid_o pulses.
- ADD overflow: sign(A)==sign(B) && sign(R)!=sign(A).
- SUB overflow: sign(A)!=sign(B) && sign(R)!=sign(A).
- ovf_o=0 for every other op.

Decomposition:
- Package alu_pkg holds:
  - the op_e enum (C_WIDTH-bit) with the codes above;
  - the state_e enum;
  - the function is_legal_op().
- Sub-module alu_mul_iter (parameter D_WIDTH) contains the shift-add datapath and iteration counter.
  - Ports: clk, rst, load, a, b, busy, done, product[2D-1:0].
- alu_mc contains the FSM, the combinational single-cycle ops and the output registers.

Test Plan (D_WIDTH=34):
- Reset then ADD 5+7 -> valid_o next cycle; result 12, zero 0, ovf 0, ready stays 1.
- ADD 0x1_FFFF_FFFF + 1 (max positive) -> result 0x2_0000_0000, neg 1, ovf 1. SLT A=-1, B=1 -> result 1. SLT A=max+, B=-1 -> result 0.
- MUL 1234*5678 -> ready low for 34 cycles, valid 35 cycles after accept, result 7006652, ovf 0. MUL 0x2_0000_0000*2 -> result 0, ovf 1.
- start_i held high during MUL with ADD 1+1 -> ignored. The ADD is accepted in the OUT cycle, and valid for it follows next cycle with result 2.
- SR B=0x100, A=4 -> 0x10. SL A=34 -> result 0. Opcode 9 -> result 0, illegal 1, valid pulses.
- rst asserted 10 cycles into a MUL -> no valid pulse, ready 1, outputs 0. The next ADD completes normally.
